macarray_acc: RTL and testbench

- Parametrised successor of the fixed 4x4 MAC array.
- Computes O[MxT] = I[MxN] x W[NxT] on an ARR x ARR grid of MAC cells using column/row outer products.
- Adds runtime dimension checking, an accumulate-into-output mode, a BUSY/DONE/ERR handshake and an optional saturating accumulator.
- Sits between the host control (MNT/START) and three single-port synchronous SRAMs: input, weight and output.

---
 rtl/macarray_acc_if.sv | 52 +++++
 rtl/macarray_acc.sv | 270 +++++++++++++++++++++++++++
 tb/tb_macarray_acc.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/macarray_acc_if.sv
// ----------------------------------------------------------------------------
// macarray_acc_if
//   Bundle of the host control handshake and the three SRAM ports of the
//   MAC array accumulator.
//
//   Host side : MNT (M=[11:8] N=[7:4] T=[3:0]), START, MODE -> BUSY, DONE, ERR
//   Input SRAM: EN_I, ADDR_I -> RDATA_I (column k of I, lane m)
//   Weight SRAM: EN_W, ADDR_W -> RDATA_W (row k of W, lane t)
//   Output SRAM: EN_O, RW_O, ADDR_O, WDATA_O -> RDATA_O (row m of O, lane t)
//
//   master : host + memory side (drives requests and read data)
//   slave  : the accelerator
// ----------------------------------------------------------------------------
interface macarray_acc_if #(
  parameter int ARR   = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 16,
  parameter int AW    = 4
);
  logic [11:0]          MNT;
  logic                 START;
  logic                 MODE;
  logic                 BUSY;
  logic                 DONE;
  logic                 ERR;

  logic                 EN_I;
  logic [AW-1:0]        ADDR_I;
  logic [ARR*DW-1:0]    RDATA_I;

  logic                 EN_W;
  logic [AW-1:0]        ADDR_W;
  logic [ARR*DW-1:0]    RDATA_W;

  logic                 EN_O;
  logic                 RW_O;
  logic [AW-1:0]        ADDR_O;
  logic [ARR*ACC_W-1:0] WDATA_O;
  logic [ARR*ACC_W-1:0] RDATA_O;

  modport master (
    output MNT, START, MODE, RDATA_I, RDATA_W, RDATA_O,
    input  BUSY, DONE, ERR, EN_I, ADDR_I, EN_W, ADDR_W,
           EN_O, RW_O, ADDR_O, WDATA_O
  );

  modport slave (
    input  MNT, START, MODE, RDATA_I, RDATA_W, RDATA_O,
    output BUSY, DONE, ERR, EN_I, ADDR_I, EN_W, ADDR_W,
           EN_O, RW_O, ADDR_O, WDATA_O
  );
endinterface

// File: rtl/macarray_acc.sv
// ----------------------------------------------------------------------------
// macarray_acc
//   O[MxT] = I[MxN] x W[NxT] on an ARR x ARR grid of MAC cells, built from
//   N column/row outer products. Results are written to the output SRAM
//   either directly (MODE=0) or added onto the existing contents (MODE=1,
//   read-modify-write per row).
//
//   Ports
//     CLK  : clock, rising edge
//     RST  : synchronous, active-high reset
//     bus  : macarray_acc_if.slave (host handshake + I/W/O SRAM ports)
//
//   Build option
//     MACARRAY_ACC_SAT_EN : when defined, every accumulate step and the
//                           MODE=1 output add clamp to 2^ACC_W-1; otherwise
//                           they wrap modulo 2^ACC_W. Timing is identical.
//
//   Sub-modules (this file)
//     macarray_add  : ACC_W adder, wrapping or saturating
//     macarray_cell : one MAC lane, acc += a*b
// ----------------------------------------------------------------------------

// Adder shared by the MAC cells and the MODE=1 output path so both honour
// the same overflow policy.
module macarray_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
`ifdef MACARRAY_ACC_SAT_EN
  logic [W:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};
  // Operands are unsigned, so a carry out is the only overflow case; once
  // a lane sits at all-ones it can never come back down.
  assign y   = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
  assign y = a + b;
`endif
endmodule

// One grid cell: clears on clr (operation start) and on reset, otherwise
// adds the zero-extended unsigned product whenever en is high.
module macarray_cell #(
  parameter int DW    = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc
);
  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] nxt;

  assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

  macarray_add #(.W(ACC_W)) u_add (
    .a (acc),
    .b (ACC_W'(prod)),
    .y (nxt)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= nxt;
  end
endmodule

module macarray_acc #(
  parameter int ARR   = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  macarray_acc_if.slave bus
);
  localparam logic [3:0] ARR4 = 4'(ARR);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RD_O, WR_O, FIN} state_t;

  state_t     state;
  logic [3:0] m_r, n_r, t_r;   // latched dimensions
  logic       mode_r;
  logic [3:0] k_r;             // current load index
  logic [3:0] row_r;           // current output row
  logic       mac_vld;         // SRAM data for a load issued last cycle is on RDATA_I/W

  logic [3:0] f_m, f_n, f_t;
  logic       mnt_ok, start_ok;

  logic [ARR-1:0][ARR-1:0][ACC_W-1:0] acc;
  logic [ARR-1:0][ACC_W-1:0]          acc_row;
  logic [ARR-1:0][ACC_W-1:0]          sum_o;
  logic [ARR-1:0][ACC_W-1:0]          wdata;

  assign f_m = bus.MNT[11:8];
  assign f_n = bus.MNT[7:4];
  assign f_t = bus.MNT[3:0];

  assign mnt_ok   = (f_m != 4'd0) && (f_m <= ARR4) &&
                    (f_n != 4'd0) && (f_n <= ARR4) &&
                    (f_t != 4'd0) && (f_t <= ARR4);
  assign start_ok = (state == IDLE) && bus.START && mnt_ok;

  // --------------------------------------------------------------------------
  // Control FSM; every bus output it drives is registered here.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      m_r        <= '0;
      n_r        <= '0;
      t_r        <= '0;
      mode_r     <= 1'b0;
      k_r        <= '0;
      row_r      <= '0;
      bus.BUSY   <= 1'b0;
      bus.DONE   <= 1'b0;
      bus.ERR    <= 1'b0;
      bus.EN_I   <= 1'b0;
      bus.EN_W   <= 1'b0;
      bus.ADDR_I <= '0;
      bus.ADDR_W <= '0;
      bus.EN_O   <= 1'b0;
      bus.RW_O   <= 1'b0;
      bus.ADDR_O <= '0;
    end else begin
      bus.DONE <= 1'b0;
      bus.ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            if (mnt_ok) begin
              m_r        <= f_m;
              n_r        <= f_n;
              t_r        <= f_t;
              mode_r     <= bus.MODE;
              k_r        <= '0;
              state      <= LOAD;
              bus.BUSY   <= 1'b1;
              bus.EN_I   <= 1'b1;
              bus.EN_W   <= 1'b1;
              bus.ADDR_I <= '0;
              bus.ADDR_W <= '0;
            end else begin
              bus.ERR <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (k_r == n_r - 4'd1) begin
            state      <= DRAIN;
            bus.EN_I   <= 1'b0;
            bus.EN_W   <= 1'b0;
            bus.ADDR_I <= '0;
            bus.ADDR_W <= '0;
          end else begin
            k_r        <= k_r + 4'd1;
            bus.ADDR_I <= AW'(k_r + 4'd1);
            bus.ADDR_W <= AW'(k_r + 4'd1);
          end
        end

        // The final product lands in the grid at the end of this cycle.
        DRAIN: begin
          row_r      <= '0;
          bus.EN_O   <= 1'b1;
          bus.ADDR_O <= '0;
          if (mode_r) begin
            state    <= RD_O;
            bus.RW_O <= 1'b0;
          end else begin
            state    <= WR_O;
            bus.RW_O <= 1'b1;
          end
        end

        // Same row address, flip to write; read data arrives next cycle.
        RD_O: begin
          state    <= WR_O;
          bus.RW_O <= 1'b1;
        end

        WR_O: begin
          if (row_r == m_r - 4'd1) begin
            state      <= FIN;
            bus.EN_O   <= 1'b0;
            bus.RW_O   <= 1'b0;
            bus.ADDR_O <= '0;
            bus.BUSY   <= 1'b0;
            bus.DONE   <= 1'b1;
          end else begin
            row_r      <= row_r + 4'd1;
            bus.ADDR_O <= AW'(row_r + 4'd1);
            if (mode_r) begin
              state    <= RD_O;
              bus.RW_O <= 1'b0;
            end
          end
        end

        // START here is deliberately dropped; only IDLE accepts it.
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) mac_vld <= 1'b0;
    else     mac_vld <= bus.EN_I;
  end

  // --------------------------------------------------------------------------
  // MAC grid. Cells outside the active MxT window never enable, so they keep
  // the zero they were cleared to at start.
  // --------------------------------------------------------------------------
  for (genvar m = 0; m < ARR; m++) begin : g_row
    for (genvar t = 0; t < ARR; t++) begin : g_col
      macarray_cell #(.DW(DW), .ACC_W(ACC_W)) u_cell (
        .clk (CLK),
        .rst (RST),
        .clr (start_ok),
        .en  (mac_vld && (4'(m) < m_r) && (4'(t) < t_r)),
        .a   (bus.RDATA_I[DW*m +: DW]),
        .b   (bus.RDATA_W[DW*t +: DW]),
        .acc (acc[m][t])
      );
    end
  end

  // --------------------------------------------------------------------------
  // Output row path
  // --------------------------------------------------------------------------
  always_comb begin
    acc_row = '0;
    for (int m = 0; m < ARR; m++)
      if (row_r == 4'(m)) acc_row = acc[m];
  end

  for (genvar t = 0; t < ARR; t++) begin : g_oadd
    macarray_add #(.W(ACC_W)) u_oadd (
      .a (acc_row[t]),
      .b (bus.RDATA_O[ACC_W*t +: ACC_W]),
      .y (sum_o[t])
    );
  end

  // Lanes beyond T: zero in overwrite mode, passed through untouched in
  // accumulate mode so the row's other columns survive the rewrite.
  always_comb begin
    wdata = '0;
    if (state == WR_O) begin
      for (int t = 0; t < ARR; t++) begin
        if (4'(t) < t_r) wdata[t] = mode_r ? sum_o[t] : acc_row[t];
        else             wdata[t] = mode_r ? bus.RDATA_O[ACC_W*t +: ACC_W] : '0;
      end
    end
  end

  assign bus.WDATA_O = wdata;
endmodule

// File: tb/tb_macarray_acc.sv
// ----------------------------------------------------------------------------
// tb_macarray_acc
//   Scoreboard bench: each issued operation pushes its expected SRAM loads,
//   output accesses, DONE/ERR cycles into queues; a negedge monitor pops and
//   compares as the DUT presents them. Expected matrices come from plain
//   sum-of-products arithmetic.
// ----------------------------------------------------------------------------
module tb_macarray_acc;
  localparam int ARR   = 4;
  localparam int DW    = 8;
  localparam int ACC_W = 16;
  localparam int AW    = 4;
  localparam int RW    = ARR*ACC_W;
  localparam longint unsigned MAXV = (64'd1 << ACC_W) - 64'd1;

  typedef struct {
    logic          rw;
    int            addr;
    logic [RW-1:0] data;
  } ev_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  macarray_acc_if #(.ARR(ARR), .DW(DW), .ACC_W(ACC_W), .AW(AW)) bus ();

  macarray_acc #(.ARR(ARR), .DW(DW), .ACC_W(ACC_W), .AW(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [ARR*DW-1:0] imem [16];
  logic [ARR*DW-1:0] wmem [16];
  logic [RW-1:0]     omem [16];
  logic [RW-1:0]     oinit[16];
  logic              pre_en = 1'b0;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  int  ld_q[$];
  ev_t ev_q[$];
  int  done_q[$];
  int  err_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM models: one-cycle read latency, write on the edge
  always @(posedge CLK) begin
    if (bus.EN_I) bus.RDATA_I <= imem[bus.ADDR_I];
    if (bus.EN_W) bus.RDATA_W <= wmem[bus.ADDR_W];
    if (bus.EN_O && !bus.RW_O) bus.RDATA_O <= omem[bus.ADDR_O];
    if (bus.EN_O &&  bus.RW_O) omem[bus.ADDR_O] <= bus.WDATA_O;
    if (pre_en) for (int r = 0; r < 16; r++) omem[r] <= oinit[r];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint unsigned fix(input longint unsigned v);
`ifdef MACARRAY_ACC_SAT_EN
    return (v > MAXV) ? MAXV : v;
`else
    return v & MAXV;
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge CLK) begin
    logic viol;
    if (bus.EN_I || bus.EN_W) begin
      if (ld_q.size() == 0) chk("spurious_load", {bus.EN_I, bus.EN_W}, 0);
      else begin
        int k;
        k = ld_q.pop_front();
        chk("load_en_busy", {bus.EN_I, bus.EN_W, bus.BUSY}, 3'b111);
        chk("addr_i", bus.ADDR_I, k);
        chk("addr_w", bus.ADDR_W, k);
      end
    end
    if (bus.EN_O) begin
      if (ev_q.size() == 0) chk("spurious_o_access", bus.EN_O, 0);
      else begin
        ev_t e;
        e = ev_q.pop_front();
        chk("o_rw", bus.RW_O, e.rw);
        chk("o_addr", bus.ADDR_O, e.addr);
        chk("o_busy", bus.BUSY, 1);
        if (e.rw) chk("o_wdata", bus.WDATA_O, e.data);
      end
    end
    if (bus.DONE) begin
      if (done_q.size() == 0) chk("spurious_done", bus.DONE, 0);
      else begin
        chk("done_cycle", cyc, done_q.pop_front());
        chk("done_busy", bus.BUSY, 0);
      end
    end
    if (bus.ERR) begin
      if (err_q.size() == 0) chk("spurious_err", bus.ERR, 0);
      else begin
        chk("err_cycle", cyc, err_q.pop_front());
        chk("err_busy", bus.BUSY, 0);
      end
    end
    viol = (!bus.EN_I && bus.ADDR_I != '0) || (!bus.EN_W && bus.ADDR_W != '0) ||
           (!bus.EN_O && bus.ADDR_O != '0) ||
           (!(bus.EN_O && bus.RW_O) && bus.WDATA_O != '0);
    chk("idle_outputs_zero", viol, 0);
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic preload_o();
    pre_en = 1'b1;
    @(negedge CLK);
    pre_en = 1'b0;
    @(negedge CLK);
  endtask

  task automatic rand_fill();
    for (int r = 0; r < 16; r++) begin
      imem[r]  = {$urandom, $urandom};
      wmem[r]  = {$urandom, $urandom};
      oinit[r] = {$urandom, $urandom};
    end
  endtask

  function automatic logic [ACC_W-1:0] olane(input int r, input int t);
    return omem[r][ACC_W*t +: ACC_W];
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  bus.BUSY, 0);
    chk({tag, "_done"},  bus.DONE, 0);
    chk({tag, "_err"},   bus.ERR, 0);
    chk({tag, "_en_i"},  bus.EN_I, 0);
    chk({tag, "_en_w"},  bus.EN_W, 0);
    chk({tag, "_en_o"},  bus.EN_O, 0);
    chk({tag, "_rw_o"},  bus.RW_O, 0);
    chk({tag, "_addr_i"}, bus.ADDR_I, 0);
    chk({tag, "_addr_w"}, bus.ADDR_W, 0);
    chk({tag, "_addr_o"}, bus.ADDR_O, 0);
    chk({tag, "_wdata"}, bus.WDATA_O, 0);
  endtask

  // Issue one START at a negedge, queue everything the DUT should do, then
  // wait (bounded) for the scoreboard to drain and compare SRAM contents.
  task automatic issue(input logic [11:0] mnt, input bit mode,
                       input bit poke_load, input bit poke_fin);
    int M, N, T, c0, done_at;
    bit legal, ok;
    logic [RW-1:0] exp_mem [ARR];
    M = int'(mnt[11:8]);
    N = int'(mnt[7:4]);
    T = int'(mnt[3:0]);
    legal = (M >= 1 && M <= ARR && N >= 1 && N <= ARR && T >= 1 && T <= ARR);
    c0 = cyc;
    done_at = 0;
    for (int r = 0; r < ARR; r++) exp_mem[r] = omem[r];
    if (!legal) err_q.push_back(c0 + 1);
    else begin
      for (int k = 0; k < N; k++) ld_q.push_back(k);
      for (int m = 0; m < M; m++) begin
        logic [RW-1:0] row;
        ev_t e;
        row = '0;
        for (int t = 0; t < ARR; t++) begin
          longint unsigned old, s;
          old = 64'(omem[m][ACC_W*t +: ACC_W]);
          if (t < T) begin
            s = 0;
            for (int k = 0; k < N; k++)
              s += 64'(imem[k][DW*m +: DW]) * 64'(wmem[k][DW*t +: DW]);
            s = fix(s);
            if (mode) s = fix(s + old);
          end else begin
            s = mode ? old : 64'd0;
          end
          row[ACC_W*t +: ACC_W] = s[ACC_W-1:0];
        end
        if (mode) begin
          e.rw = 1'b0; e.addr = m; e.data = '0;
          ev_q.push_back(e);
        end
        e.rw = 1'b1; e.addr = m; e.data = row;
        ev_q.push_back(e);
        exp_mem[m] = row;
      end
      done_at = c0 + N + M*(mode ? 2 : 1) + 2;
      done_q.push_back(done_at);
    end

    bus.MNT   = mnt;
    bus.MODE  = mode;
    bus.START = 1'b1;
    @(negedge CLK);
    if (poke_load && legal) begin
      // Illegal START while loading must be ignored (no ERR)
      bus.MNT = 12'h000;
      @(negedge CLK);
    end
    bus.START = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (poke_fin && legal && cyc == done_at) begin
        bus.START = 1'b1;
        bus.MNT   = 12'h111;
      end else begin
        bus.START = 1'b0;
      end
      if (!bus.START && ld_q.size() == 0 && ev_q.size() == 0 &&
          done_q.size() == 0 && err_q.size() == 0 && !bus.BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    bus.START = 1'b0;
    chk("op_complete", ok, 1);
    for (int r = 0; r < ARR; r++) chk("omem_row", omem[r], exp_mem[r]);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    RST       = 1'b1;
    bus.START = 1'b0;
    bus.MNT   = '0;
    bus.MODE  = 1'b0;
    rand_fill();
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    preload_o();
    RST = 1'b0;
    @(negedge CLK);

    // 1: all-ones x all-twos, full 4x4x4
    for (int r = 0; r < 16; r++) begin
      imem[r] = {ARR{8'd1}};
      wmem[r] = {ARR{8'd2}};
    end
    issue(12'h444, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < ARR; m++)
      for (int t = 0; t < ARR; t++) chk("t1_lane", olane(m, t), 16'd8);

    // 2: M=2 N=3 T=1
    rand_fill();
    for (int k = 0; k < 16; k++) begin
      for (int m = 0; m < ARR; m++) imem[k][DW*m +: DW] = DW'(m + k + 1);
      wmem[k][DW-1:0] = DW'(k + 1);
    end
    preload_o();
    issue(12'h231, 1'b0, 1'b0, 1'b0);
    chk("t2_o00", olane(0, 0), 16'd14);
    chk("t2_o10", olane(1, 0), 16'd20);
    for (int m = 0; m < 2; m++)
      for (int t = 1; t < ARR; t++) chk("t2_lane_hi_zero", olane(m, t), 16'd0);

    // 3: accumulate mode on top of 100
    for (int r = 0; r < 16; r++) begin
      imem[r]  = {ARR{8'd3}};
      wmem[r]  = {ARR{8'd3}};
      oinit[r] = {ARR{16'd100}};
    end
    preload_o();
    issue(12'h422, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < ARR; m++) begin
      chk("t3_lane0", olane(m, 0), 16'd118);
      chk("t3_lane1", olane(m, 1), 16'd118);
      chk("t3_lane2", olane(m, 2), 16'd100);
      chk("t3_lane3", olane(m, 3), 16'd100);
    end

    // 4: illegal dimensions
    issue(12'h045, 1'b0, 1'b0, 1'b0);
    issue(12'h514, 1'b0, 1'b0, 1'b0);

    // 5: overflow, all operands 255
    for (int r = 0; r < 16; r++) begin
      imem[r] = {ARR{8'd255}};
      wmem[r] = {ARR{8'd255}};
    end
    issue(12'h444, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < ARR; m++)
`ifdef MACARRAY_ACC_SAT_EN
      chk("t5_sat", olane(m, 0), 16'd65535);
`else
      chk("t5_wrap", olane(m, 0), 16'd63492);
`endif

    // 6: reset during the second load cycle, then a clean run
    rand_fill();
    preload_o();
    begin
      ld_q.push_back(0);
      ld_q.push_back(1);
      bus.MNT   = 12'h444;
      bus.MODE  = 1'b0;
      bus.START = 1'b1;
      @(negedge CLK);
      bus.START = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check_reset_outputs("midrst");
      RST = 1'b0;
      @(negedge CLK);
      chk("midrst_no_pending", ld_q.size(), 0);
    end
    issue(12'h444, 1'b0, 1'b0, 1'b0);

    // Randomized operations, with ignored STARTs sprinkled in
    for (int n = 0; n < 24; n++) begin
      logic [11:0] mnt;
      rand_fill();
      preload_o();
      mnt = {4'($urandom_range(1, ARR)), 4'($urandom_range(1, ARR)),
             4'($urandom_range(1, ARR))};
      issue(mnt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
